// File: rtl/pump_duty_scheduler.sv
// Two-pump tank fill scheduler: debounces three level probes, runs a lead/lag
// duty FSM with hysteresis and minimum on/off times, and latches dry-run / probe faults.
module pump_duty_scheduler #(
  parameter int CNT_W           = 8,
  parameter int DEBOUNCE_CYC    = 4,
  parameter int MIN_ON_CYC      = 8,
  parameter int MIN_OFF_CYC     = 6,
  parameter int DRY_TIMEOUT_CYC = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       S0,
  input  logic       S1,
  input  logic       S2,
  input  logic       clear_fault,
  output logic       pump_a,
  output logic       pump_b,
  output logic       lead_sel,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD_RUN = 3'd1,
    BOTH_RUN = 3'd2,
    COOLDOWN = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_ON_V = CNT_W'(MIN_ON_CYC);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF_CYC - 1);
  localparam logic [CNT_W-1:0] DRY_LAST = CNT_W'(DRY_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [2:0]       raw_s;
  logic [2:0]       deb_s;
  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] hold_r;
  logic [CNT_W-1:0] hold_next_s;
  logic [CNT_W-1:0] dry_r;
  logic [CNT_W-1:0] dry_next_s;
  logic             lead_next_s;
  logic [1:0]       code_next_s;
  logic             pa_next_s;
  logic             pb_next_s;
  logic             empty_s;
  logic             low_s;
  logic             mid_s;
  logic             full_s;
  logic             invalid_s;
  logic             min_on_ok_s;
  logic             dry_hit_s;
  logic             run_now_s;
  logic             run_next_s;

  assign raw_s = {S2, S1, S0};

  for (genvar g = 0; g < 3; g++) begin : g_deb
    logic             deb_bit_r;
    logic [CNT_W-1:0] cnt_r;

    // Per-probe debouncer: accept a new value only after it differs for DEBOUNCE_CYC cycles in a row.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        deb_bit_r <= 1'b0;
        cnt_r     <= '0;
      end else if (raw_s[g] == deb_bit_r) begin
        cnt_r     <= '0;
      end else if (cnt_r == DEB_LAST) begin
        deb_bit_r <= raw_s[g];
        cnt_r     <= '0;
      end else begin
        cnt_r     <= cnt_r + 1'b1;
      end
    end

    assign deb_s[g] = deb_bit_r;
  end

  assign empty_s     = (deb_s == 3'b000);
  assign low_s       = (deb_s == 3'b001);
  assign mid_s       = (deb_s == 3'b011);
  assign full_s      = (deb_s == 3'b111);
  assign invalid_s   = !(empty_s || low_s || mid_s || full_s);
  assign min_on_ok_s = (hold_r >= MIN_ON_V);
  assign dry_hit_s   = !deb_s[0] && (dry_r >= DRY_LAST);

  // Next-state, lead rotation and fault code; priority is invalid > dry > full stop > empty > other.
  always_comb begin
    next_s      = state_r;
    lead_next_s = lead_sel;
    code_next_s = fault_code;
    case (state_r)
      IDLE: begin
        if (invalid_s) begin
          next_s      = FAULT;
          code_next_s = 2'b01;
        end else if (empty_s) begin
          next_s = BOTH_RUN;
        end else if (low_s) begin
          next_s = LEAD_RUN;
        end else begin
          next_s = IDLE;
        end
      end
      LEAD_RUN: begin
        if (invalid_s) begin
          next_s      = FAULT;
          code_next_s = 2'b01;
        end else if (dry_hit_s) begin
          next_s      = FAULT;
          code_next_s = 2'b10;
        end else if (full_s && min_on_ok_s) begin
          next_s      = COOLDOWN;
          lead_next_s = !lead_sel;
        end else if (empty_s) begin
          next_s = BOTH_RUN;
        end else begin
          next_s = LEAD_RUN;
        end
      end
      BOTH_RUN: begin
        if (invalid_s) begin
          next_s      = FAULT;
          code_next_s = 2'b01;
        end else if (dry_hit_s) begin
          next_s      = FAULT;
          code_next_s = 2'b10;
        end else if ((mid_s || full_s) && min_on_ok_s) begin
          if (full_s) begin
            next_s      = COOLDOWN;
            lead_next_s = !lead_sel;
          end else begin
            next_s = LEAD_RUN;
          end
        end else begin
          next_s = BOTH_RUN;
        end
      end
      COOLDOWN: begin
        if (invalid_s) begin
          next_s      = FAULT;
          code_next_s = 2'b01;
        end else if (hold_r >= OFF_LAST) begin
          next_s = IDLE;
        end else begin
          next_s = COOLDOWN;
        end
      end
      FAULT: begin
        if (clear_fault && !invalid_s) begin
          next_s      = COOLDOWN;
          code_next_s = 2'b00;
        end else begin
          next_s = FAULT;
        end
      end
      default: begin
        next_s      = COOLDOWN;
        code_next_s = 2'b00;
      end
    endcase
  end

  // Timers and pump decode derived from the chosen next state.
  always_comb begin
    run_now_s  = (state_r == LEAD_RUN) || (state_r == BOTH_RUN);
    run_next_s = (next_s == LEAD_RUN) || (next_s == BOTH_RUN);

    if (next_s != state_r) begin
      hold_next_s = '0;
    end else if (hold_r == CNT_MAX) begin
      hold_next_s = hold_r;
    end else begin
      hold_next_s = hold_r + 1'b1;
    end

    // The dry timer only accumulates while running on a dry low probe.
    if (run_now_s && run_next_s && !deb_s[0]) begin
      if (dry_r == CNT_MAX) begin
        dry_next_s = dry_r;
      end else begin
        dry_next_s = dry_r + 1'b1;
      end
    end else begin
      dry_next_s = '0;
    end

    case (next_s)
      LEAD_RUN: begin
        pa_next_s = !lead_next_s;
        pb_next_s = lead_next_s;
      end
      BOTH_RUN: begin
        pa_next_s = 1'b1;
        pb_next_s = 1'b1;
      end
      default: begin
        pa_next_s = 1'b0;
        pb_next_s = 1'b0;
      end
    endcase
  end

  // State, timers and registered outputs; async reset drops both pumps at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= COOLDOWN;
      hold_r     <= '0;
      dry_r      <= '0;
      lead_sel   <= 1'b0;
      pump_a     <= 1'b0;
      pump_b     <= 1'b0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state_r    <= next_s;
      hold_r     <= hold_next_s;
      dry_r      <= dry_next_s;
      lead_sel   <= lead_next_s;
      pump_a     <= pa_next_s;
      pump_b     <= pb_next_s;
      fault      <= (next_s == FAULT);
      fault_code <= code_next_s;
    end
  end

  assign state = state_r;

endmodule
